// File: rtl/dmem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_pkg
//  Description : Shared types and constants for the data-memory bus arbiter.
//                - bus_state_t : sequencer states (IDLE / BUSY / RESP)
//                - master_t    : master identifiers (CPU MEM stage / debug)
//                - IO_SEL_BIT  : address bit that selects the IO region
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    typedef enum logic {
        M_CPU = 1'b0,
        M_DBG = 1'b1
    } master_t;

    // addr[IO_SEL_BIT] = 1 selects memory-mapped IO, 0 selects RAM
    localparam int IO_SEL_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin pick. On a tie the master
//                that did not win last time is chosen; a lone requester
//                always wins regardless of history.
//  Ports       : i_req0        - request from master 0 (CPU)
//                i_req1        - request from master 1 (debug)
//                i_last_grant  - master that completed the previous access
//                o_grant_valid - at least one request present
//                o_grant_id    - selected master (valid with o_grant_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_bus_pkg::*;
(
    input  logic    i_req0,
    input  logic    i_req1,
    input  master_t i_last_grant,
    output logic    o_grant_valid,
    output master_t o_grant_id
);

    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        o_grant_id    = M_CPU;
        if (i_req0 && i_req1) begin
            o_grant_id = (i_last_grant == M_CPU) ? M_DBG : M_CPU;
        end else if (i_req1) begin
            o_grant_id = M_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_arbiter
//  Description : Shares the single data-memory/IO decoder port between the
//                pipeline MEM stage (master 0) and the debug/loader port
//                (master 1). Each access is IDLE -> BUSY (wait cycles) ->
//                RESP, with the wait count chosen by address region.
//  Ports       : clk, reset           - clock / async active-high reset
//                m0_* / m1_*          - per-master req/we/addr/wdata in,
//                                       registered rdata and ack pulse out
//                bus_we/addr/wdata    - request to the decoder
//                bus_rdata            - combinational read data from decoder
//                busy                 - sequencer not IDLE
//                owner                - granted master, valid while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_arbiter
    import dmem_bus_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [CNT_W-1:0] C_MEM_WAIT = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] C_IO_WAIT  = CNT_W'(IO_WAIT);

    bus_state_t       r_state;
    bus_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    master_t          r_owner;
    master_t          r_last_grant;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_m0_rdata;
    logic [31:0]      r_m1_rdata;
    logic             r_m0_ack;
    logic             r_m1_ack;

    logic             w_grant_valid;
    master_t          w_grant_id;
    logic             w_sel_we;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [CNT_W-1:0] w_wait_load;
    logic             w_last_busy;

    rr_arb2 u_rr_arb2 (
        .i_req0        (m0_req),
        .i_req1        (m1_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Winner's request fields, latched on grant
    assign w_sel_we    = (w_grant_id == M_DBG) ? m1_we    : m0_we;
    assign w_sel_addr  = (w_grant_id == M_DBG) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_grant_id == M_DBG) ? m1_wdata : m0_wdata;
    assign w_wait_load = w_sel_addr[IO_SEL_BIT] ? C_IO_WAIT : C_MEM_WAIT;

    // Final BUSY cycle: the decoder sees the write strobe and read data is
    // sampled on the closing edge.
    assign w_last_busy = (r_state == BUSY) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = BUSY;
            BUSY:    if (r_cnt == '0)   w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, latched request and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_owner      <= M_CPU;
            r_last_grant <= M_DBG;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
        end else begin
            // Acks are single-cycle: set only on the BUSY -> RESP edge
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant_id;
                        r_we        <= w_sel_we;
                        r_bus_addr  <= w_sel_addr;
                        r_bus_wdata <= w_sel_wdata;
                        r_cnt       <= w_wait_load;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (r_owner == M_DBG) begin
                            r_m1_ack <= 1'b1;
                            if (!r_we) r_m1_rdata <= bus_rdata;
                        end else begin
                            r_m0_ack <= 1'b1;
                            if (!r_we) r_m0_rdata <= bus_rdata;
                        end
                    end
                end
                RESP: begin
                    r_last_grant <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_we    = w_last_busy && r_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bus_arbiter
//  Description : Self-checking bench for dmem_bus_arbiter. Expected accesses
//                are queued when stimulus is driven and retired by a monitor
//                when an ack is observed; each scenario task also checks its
//                own timing and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        busy, owner;
    logic [31:0] rd_key;

    // Decoder model: read data is a keyed function of the address
    assign bus_rdata = rd_key ^ bus_addr;

    always #5 clk = ~clk;

    dmem_bus_arbiter #(.MEM_WAIT(0), .IO_WAIT(2), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_we   = 0;

    // ------------------------------------------------------------------
    // Scoreboard monitor: retires one expected access per ack
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            mon_we = 0;
        end else begin
            if (bus_we) begin
                mon_we++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_we_unexpected: got bus_we=1 addr=%h, required no write", bus_addr);
                end else if (!sb[0].we || bus_addr !== sb[0].addr || bus_wdata !== sb[0].wdata) begin
                    n_fail++;
                    $display("FAIL bus_write: got addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             bus_addr, bus_wdata, sb[0].we, sb[0].addr, sb[0].wdata);
                end
            end
            if (m0_ack || m1_ack) begin
                n_checks++;
                if (m0_ack && m1_ack) begin
                    n_fail++;
                    $display("FAIL ack_overlap: got m0_ack=1 m1_ack=1, required at most one");
                end else if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: got m0_ack=%b m1_ack=%b, required none", m0_ack, m1_ack);
                end else begin
                    mon_e = sb.pop_front();
                    if (m1_ack !== mon_e.id || owner !== mon_e.id) begin
                        n_fail++;
                        $display("FAIL ack_master: got ack_id=%b owner=%b, required %b", m1_ack, owner, mon_e.id);
                    end else if (mon_we != (mon_e.we ? 1 : 0)) begin
                        n_fail++;
                        $display("FAIL bus_we_count: got %0d, required %0d", mon_we, mon_e.we ? 1 : 0);
                    end else if (!mon_e.we && (mon_e.id ? m1_rdata : m0_rdata) !== mon_e.rdata) begin
                        n_fail++;
                        $display("FAIL rdata: got %h, required %h", mon_e.id ? m1_rdata : m0_rdata, mon_e.rdata);
                    end
                end
                mon_we = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        rd_key = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || bus_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b m0_ack=%b m1_ack=%b bus_we=%b, required all 0",
                     busy, m0_ack, m1_ack, bus_we);
        end
        n_checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h, required 0 0", m0_rdata, m1_rdata);
        end
        n_checks++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h wdata=%h owner=%b, required 0 0 0", bus_addr, bus_wdata, owner);
        end
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_ram_read();
        int lat = 0;
        int nacks = 0;
        int nwe = 0;
        @(negedge clk);
        rd_key = 32'hDEADBEEF ^ 32'h10;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wdata = 32'h0;
        sb.push_back('{id: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0, rdata: 32'hDEADBEEF});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus_we) nwe++;
            if (m0_ack) begin
                nacks++;
                if (lat == 0) lat = c;
                m0_req = 0;
            end
        end
        n_checks++;
        if (lat != 2 || nacks != 1) begin
            n_fail++;
            $display("FAIL ram_read_ack: got latency=%0d pulses=%0d, required 2 1", lat, nacks);
        end
        n_checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ram_read_data: got %h, required deadbeef", m0_rdata);
        end
        n_checks++;
        if (nwe != 0) begin
            n_fail++;
            $display("FAIL ram_read_we: got %0d strobes, required 0", nwe);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_io_write();
        int lat = 0;
        int nacks = 0;
        int nbusy = 0;
        int nwe = 0;
        int we_at = 0;
        int addr_bad = 0;
        logic [31:0] m1_rd_before;
        @(negedge clk);
        m1_rd_before = m1_rdata;
        rd_key = 32'h5555_0000;
        m1_req = 1; m1_we = 1; m1_addr = 32'h84; m1_wdata = 32'h0000_0ABC;
        sb.push_back('{id: 1'b1, we: 1'b1, addr: 32'h84, wdata: 32'h0000_0ABC, rdata: 32'h0});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (busy && !m0_ack && !m1_ack) begin
                nbusy++;
                if (bus_addr !== 32'h84) addr_bad++;
                if (bus_we) we_at = nbusy;
            end
            if (bus_we) nwe++;
            if (m1_ack) begin
                nacks++;
                if (lat == 0) lat = c;
                m1_req = 0;
            end
        end
        m1_we = 0;
        n_checks++;
        if (nbusy != 3 || addr_bad != 0) begin
            n_fail++;
            $display("FAIL io_write_busy: got busy_cycles=%0d bad_addr=%0d, required 3 0", nbusy, addr_bad);
        end
        n_checks++;
        if (nwe != 1 || we_at != 3) begin
            n_fail++;
            $display("FAIL io_write_we: got strobes=%0d at_busy=%0d, required 1 3", nwe, we_at);
        end
        n_checks++;
        if (lat != 4 || nacks != 1) begin
            n_fail++;
            $display("FAIL io_write_ack: got latency=%0d pulses=%0d, required 4 1", lat, nacks);
        end
        n_checks++;
        if (m1_rdata !== m1_rd_before) begin
            n_fail++;
            $display("FAIL io_write_rdata: got %h, required %h", m1_rdata, m1_rd_before);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tie_after_reset();
        int  acks = 0;
        int  last_c = 0;
        logic order [4];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_key = 32'h1234_0000;
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        m1_req = 1; m1_we = 0; m1_addr = 32'h30;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{id: i[0], we: 1'b0, addr: (i[0] ? 32'h30 : 32'h20), wdata: 32'h0,
                           rdata: 32'h1234_0000 ^ (i[0] ? 32'h30 : 32'h20)});
        end
        for (int c = 1; c <= 20 && acks < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                order[acks] = m1_ack;
                acks++;
                last_c = c;
                if (acks == 4) begin
                    m0_req = 0;
                    m1_req = 0;
                end
            end
        end
        m0_req = 0; m1_req = 0;
        n_checks++;
        if (acks != 4 || last_c != 11) begin
            n_fail++;
            $display("FAIL tie_count: got acks=%0d last_cycle=%0d, required 4 11", acks, last_c);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i < acks && order[i] !== i[0]) begin
                n_fail++;
                $display("FAIL tie_order[%0d]: got master %b, required %b", i, order[i], i[0]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_dropped_req();
        int lat = 0;
        int nacks = 0;
        int nbusy = 0;
        @(negedge clk);
        rd_key = 32'h0F0F_0F0F;
        m0_req = 1; m0_we = 0; m0_addr = 32'h80;
        sb.push_back('{id: 1'b0, we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h0F0F_0F0F ^ 32'h80});
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            m0_req = 0;
            if (busy && !m0_ack) nbusy++;
            if (m0_ack) begin
                nacks++;
                if (lat == 0) lat = c;
            end
        end
        n_checks++;
        if (nacks != 1 || lat != 4 || nbusy != 3) begin
            n_fail++;
            $display("FAIL dropped_req: got pulses=%0d latency=%0d busy=%0d, required 1 4 3", nacks, lat, nbusy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_write();
        int nacks = 0;
        int nwe = 0;
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_addr = 32'h88; m1_wdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus_we !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_ctrl: got busy=%b bus_we=%b acks=%b%b, required 0 0 00",
                     busy, bus_we, m0_ack, m1_ack);
        end
        n_checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async_rdata: got %h %h, required 0 0", m0_rdata, m1_rdata);
        end
        m1_req = 0; m1_we = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) nacks++;
            if (bus_we) nwe++;
        end
        n_checks++;
        if (nacks != 0 || nwe != 0 || m1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dropped: got acks=%0d strobes=%0d m1_rdata=%h, required 0 0 0",
                     nacks, nwe, m1_rdata);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int acks = 0;
        int t[4];
        @(negedge clk);
        rd_key = 32'hA5A5_0000;
        m0_req = 1; m0_we = 0; m0_addr = 32'h14;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{id: 1'b0, we: 1'b0, addr: 32'h14, wdata: 32'h0, rdata: 32'hA5A5_0014});
        end
        for (int c = 1; c <= 20 && acks < 4; c++) begin
            @(negedge clk);
            if (m0_ack) begin
                t[acks] = c;
                acks++;
                if (acks == 4) m0_req = 0;
            end
        end
        m0_req = 0;
        n_checks++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d acks, required 4", acks);
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (t[i] - t[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 3", i, t[i] - t[i-1]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_ram_read();
        test_io_write();
        test_tie_after_reset();
        test_dropped_req();
        test_reset_mid_write();
        test_back_to_back();
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
